// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath width.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry/borrow out.
// Signed overflow output exists only when ALU_FLAGS_EN is defined.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ALU_FLAGS_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  // Subtraction is a + ~b + ~cin; the raw carry is then the inverse of the borrow.
  assign b_eff = b ^ {WIDTH{sub}};
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin ^ sub};
  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH] ^ sub;

`ifdef ALU_FLAGS_EN
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif

endmodule

// File: rtl/alu_32bit.sv
// Registered four-function ALU: opcode mux plus output flops, one cycle latency.
// Optional ALU_FLAGS_EN adds registered zero and signed-overflow outputs.
module alu_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic [1:0]       ctrl,
`ifdef ALU_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] alu_out,
  output logic             c_out
);

  // No handshake: operands are taken every cycle and the result is valid
  // on the outputs for the whole cycle following the sampling edge.
  alu_op_t          op;
  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic [WIDTH-1:0] next_out;
  logic             next_c;

  assign op = alu_op_t'(ctrl);

`ifdef ALU_FLAGS_EN
  logic as_ovf;
  logic next_ovf;
`endif

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (in_a),
    .b     (in_b),
    .cin   (in_c),
    .sub   (op == OP_SUB),
`ifdef ALU_FLAGS_EN
    .ovf   (as_ovf),
`endif
    .sum   (as_sum),
    .carry (as_carry)
  );

  always_comb begin
    next_out = '0;
    next_c   = 1'b0;
`ifdef ALU_FLAGS_EN
    next_ovf = 1'b0;
`endif
    case (op)
      OP_ADD, OP_SUB: begin
        next_out = as_sum;
        next_c   = as_carry;
`ifdef ALU_FLAGS_EN
        next_ovf = as_ovf;
`endif
      end
      OP_AND: next_out = in_a & in_b;
      OP_OR:  next_out = in_a | in_b;
      default: next_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out <= '0;
      c_out   <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      alu_out <= next_out;
      c_out   <= next_c;
`ifdef ALU_FLAGS_EN
      zero    <= (next_out == '0);
      ovf     <= next_ovf;
`endif
    end
  end

endmodule

// File: tb/tb_alu_32bit.sv
// Scoreboard bench for alu_32bit: randomized and directed operations checked
// against an arithmetic reference model, one result per cycle.
module tb_alu_32bit;
  import alu_pkg::*;

  localparam int W = ALU_W;
`ifdef ALU_FLAGS_EN
  localparam int EXP_W = W + 3;
`else
  localparam int EXP_W = W + 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_c;
  logic [1:0]   ctrl;
  logic [W-1:0] alu_out;
  logic         c_out;
`ifdef ALU_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               checks_total;
  int               checks_passed;

  alu_32bit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_c    (in_c),
    .ctrl    (ctrl),
`ifdef ALU_FLAGS_EN
    .zero    (zero),
    .ovf     (ovf),
`endif
    .alu_out (alu_out),
    .c_out   (c_out)
  );

  // Clock and initial reset level.
  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    in_a  = '0;
    in_b  = '0;
    in_c  = 1'b0;
    ctrl  = 2'd0;
    forever #5 clk = ~clk;
  end

  // Reference model in plain 64-bit arithmetic.
  function automatic logic [EXP_W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c, input logic [1:0] op);
    longint unsigned ua, ub, uc, res;
    longint          sa, sb, sres;
    logic [W-1:0]    out;
    logic            carry;
    logic            v;
    ua = 64'(a); ub = 64'(b); uc = 64'(c);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    carry = 1'b0;
    v     = 1'b0;
    sres  = 0;
    case (op)
      2'd0: begin
        res   = ua + ub + uc;
        out   = res[W-1:0];
        carry = (res > 64'hFFFF_FFFF);
        sres  = sa + sb + longint'(uc);
        v     = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
      end
      2'd1: begin
        res   = ua - ub - uc;
        out   = res[W-1:0];
        carry = (ua < ub + uc);
        sres  = sa - sb - longint'(uc);
        v     = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
      end
      2'd2: out = a & b;
      default: out = a | b;
    endcase
`ifdef ALU_FLAGS_EN
    return {(out == '0), v, carry, out};
`else
    if (v && sres == 0) out = out;
    return {carry, out};
`endif
  endfunction

  // Driver tasks: inputs change on the falling edge, expected result queued.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [1:0] op, input string name);
    @(negedge clk);
    rst_n = 1'b1;
    in_a  = a;
    in_b  = b;
    in_c  = c;
    ctrl  = op;
    exp_q.push_back(model(a, b, c, op));
    name_q.push_back(name);
  endtask

  task automatic drive_reset(input logic [W-1:0] a, input logic [1:0] op, input string name);
    @(negedge clk);
    rst_n = 1'b0;
    in_a  = a;
    in_b  = a;
    in_c  = 1'b1;
    ctrl  = op;
    exp_q.push_back('0);
    name_q.push_back(name);
  endtask

  // Monitor: one result per clock, sampled just after the rising edge.
  initial begin
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] got_v;
    string            nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
`ifdef ALU_FLAGS_EN
        got_v = {zero, ovf, c_out, alu_out};
`else
        got_v = {c_out, alu_out};
`endif
        checks_total++;
        if (got_v === exp_v) checks_passed++;
        else $display("FAIL %s: got {flags,c,out}=%h required %h", nm, got_v, exp_v);
      end
    end
  end

  // Stimulus and final report.
  initial begin
    logic [W-1:0] ra, rb;
    checks_total  = 0;
    checks_passed = 0;

    drive_reset(32'hFFFF_FFFF, 2'd0, "reset_0");
    drive_reset(32'hFFFF_FFFF, 2'd0, "reset_1");
    drive_op(32'h1, 32'h0, 1'b0, 2'd0, "post_reset_add");

    drive_op(32'hFFFF_FFFF, 32'h0, 1'b1, 2'd0, "add_wrap");
    drive_op(32'h7,         32'hF, 1'b0, 2'd0, "add_small");
    drive_op(32'h1,         32'h0, 1'b1, 2'd1, "sub_borrow_in");
    drive_op(32'h0,         32'h0, 1'b1, 2'd1, "sub_wrap");
    drive_op(32'h7,         32'hF, 1'b0, 2'd1, "sub_neg");
    drive_op(32'h11,        32'h10, 1'b1, 2'd2, "and_basic");
    drive_op(32'h1,         32'h0, 1'b1, 2'd3, "or_basic");
    drive_op(32'h7FFF_FFFF, 32'h1, 1'b0, 2'd0, "add_signed_ovf");
    drive_op(32'h5,         32'h5, 1'b0, 2'd1, "sub_zero");

    drive_op(32'h0101, 32'h0110, 1'b0, 2'd0, "b2b_add");
    drive_op(32'h0101, 32'h0110, 1'b0, 2'd1, "b2b_sub");
    drive_op(32'h0101, 32'h0110, 1'b0, 2'd2, "b2b_and");
    drive_op(32'h0101, 32'h0110, 1'b0, 2'd3, "b2b_or");
    drive_reset(32'hFFFF_FFFF, 2'd0, "mid_reset");
    drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'd0, "after_reset_add");

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFF_FFFF;
        1: ra = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
      if ($urandom_range(0, 29) == 0)
        drive_reset($urandom, 2'($urandom_range(0, 3)), "rand_reset");
      else
        drive_op(ra, rb, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks_total++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
